// File: rtl/bpu_history_scheduler.sv
// gshare history sequencer: speculative/committed GHR, in-order checkpoint
// queue of in-flight predictions, PHT training and mispredict/flush recovery.
module bpu_history_scheduler #(
  parameter int GHR_LENGTH  = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter int PC_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pred_valid_i,
  output logic                             pred_ready_o,
  input  logic [PC_WIDTH-1:0]              pred_pc_i,
  input  logic                             pred_taken_i,
  output logic [GHR_LENGTH-1:0]            ghr_o,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  input  logic                             res_taken_i,
  output logic                             upd_valid_o,
  output logic [PC_WIDTH-1:0]              upd_pc_o,
  output logic [GHR_LENGTH-1:0]            upd_ghr_o,
  output logic                             upd_taken_o,
  output logic                             mispredict_o,
  input  logic                             flush_i,
  output logic [$clog2(QUEUE_DEPTH):0]     occupancy_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    NORMAL,
    RECOVER
  } state_e;

  state_e state_q, state_d;

  logic [PC_WIDTH-1:0]   pc_q  [QUEUE_DEPTH];
  logic [GHR_LENGTH-1:0] ghr_q [QUEUE_DEPTH];
  logic                  tk_q  [QUEUE_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [GHR_LENGTH-1:0] spec_q, spec_d;
  logic [GHR_LENGTH-1:0] arch_q, arch_d;

  logic                  upd_valid_q;
  logic [PC_WIDTH-1:0]   upd_pc_q;
  logic [GHR_LENGTH-1:0] upd_ghr_q;
  logic                  upd_taken_q;
  logic                  misp_q;

  logic                  full;
  logic                  empty;
  logic                  pred_acc;
  logic                  res_acc;
  logic                  misp;
  logic                  push;
  logic [PC_WIDTH-1:0]   head_pc;
  logic [GHR_LENGTH-1:0] head_ghr;
  logic                  head_tk;

  assign full     = (cnt_q == CW'(QUEUE_DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_pc  = pc_q[head_q];
  assign head_ghr = ghr_q[head_q];
  assign head_tk  = tk_q[head_q];

  // Ready is purely registered: a pop in the same cycle never frees a slot.
  assign pred_ready_o = (state_q == NORMAL) && !full;
  assign res_ready_o  = !empty;

  assign pred_acc = pred_valid_i & pred_ready_o;
  assign res_acc  = res_valid_i & res_ready_o;
  assign misp     = res_acc & (res_taken_i != head_tk);

  assign ghr_o        = spec_q;
  assign occupancy_o  = cnt_q;
  assign upd_valid_o  = upd_valid_q;
  assign upd_pc_o     = upd_pc_q;
  assign upd_ghr_o    = upd_ghr_q;
  assign upd_taken_o  = upd_taken_q;
  assign mispredict_o = misp_q;

  always_comb begin
    state_d = NORMAL;
    spec_d  = spec_q;
    arch_d  = arch_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    push    = 1'b0;

    if (res_acc) begin
      arch_d = {arch_q[GHR_LENGTH-2:0], res_taken_i};
      head_d = head_q + PW'(1);
      cnt_d  = cnt_q - CW'(1);
    end

    // Flush restores from committed history including this cycle's resolve.
    if (flush_i) begin
      state_d = RECOVER;
      spec_d  = arch_d;
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
    end else if (misp) begin
      state_d = RECOVER;
      spec_d  = {head_ghr[GHR_LENGTH-2:0], res_taken_i};
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
    end else if (pred_acc) begin
      push   = 1'b1;
      tail_d = tail_q + PW'(1);
      cnt_d  = cnt_d + CW'(1);
      spec_d = {spec_q[GHR_LENGTH-2:0], pred_taken_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= NORMAL;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      spec_q  <= '0;
      arch_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      spec_q  <= spec_d;
      arch_q  <= arch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]  <= pred_pc_i;
      ghr_q[tail_q] <= spec_q;
      tk_q[tail_q]  <= pred_taken_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_ghr_q   <= '0;
      upd_taken_q <= 1'b0;
      misp_q      <= 1'b0;
    end else begin
      upd_valid_q <= res_acc;
      misp_q      <= misp;
      if (res_acc) begin
        upd_pc_q    <= head_pc;
        upd_ghr_q   <= head_ghr;
        upd_taken_q <= res_taken_i;
      end
    end
  end

endmodule

// File: tb/tb_bpu_history_scheduler.sv
// Directed and randomized checks of bpu_history_scheduler against a
// queue-based behavioural model.
module tb_bpu_history_scheduler;

  logic        clk;
  logic        rst;
  logic        pred_valid_i;
  logic        pred_ready_o;
  logic [31:0] pred_pc_i;
  logic        pred_taken_i;
  logic [7:0]  ghr_o;
  logic        res_valid_i;
  logic        res_ready_o;
  logic        res_taken_i;
  logic        upd_valid_o;
  logic [31:0] upd_pc_o;
  logic [7:0]  upd_ghr_o;
  logic        upd_taken_o;
  logic        mispredict_o;
  logic        flush_i;
  logic [2:0]  occupancy_o;

  bpu_history_scheduler #(
    .GHR_LENGTH (8),
    .QUEUE_DEPTH(4),
    .PC_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid_i(pred_valid_i),
    .pred_ready_o(pred_ready_o),
    .pred_pc_i   (pred_pc_i),
    .pred_taken_i(pred_taken_i),
    .ghr_o       (ghr_o),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_taken_i (res_taken_i),
    .upd_valid_o (upd_valid_o),
    .upd_pc_o    (upd_pc_o),
    .upd_ghr_o   (upd_ghr_o),
    .upd_taken_o (upd_taken_o),
    .mispredict_o(mispredict_o),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  g;
    logic        t;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  m_spec;
  logic [7:0]  m_arch;
  bit          m_rec;
  logic        m_uv;
  logic [31:0] m_upc;
  logic [7:0]  m_ughr;
  logic        m_utk;
  logic        m_misp;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_spec = 8'h00;
    m_arch = 8'h00;
    m_rec  = 1'b0;
    m_uv   = 1'b0;
    m_upc  = 32'h0;
    m_ughr = 8'h00;
    m_utk  = 1'b0;
    m_misp = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ghr"}, 32'(ghr_o), 32'(m_spec));
    chk({tag, "_occ"}, 32'(occupancy_o), 32'(mq.size()));
    chk({tag, "_prdy"}, 32'(pred_ready_o), 32'(!m_rec && mq.size() < 4));
    chk({tag, "_rrdy"}, 32'(res_ready_o), 32'(mq.size() > 0));
    chk({tag, "_uv"}, 32'(upd_valid_o), 32'(m_uv));
    chk({tag, "_misp"}, 32'(mispredict_o), 32'(m_misp));
    if (m_uv) begin
      chk({tag, "_upc"}, upd_pc_o, m_upc);
      chk({tag, "_ughr"}, 32'(upd_ghr_o), 32'(m_ughr));
      chk({tag, "_utk"}, 32'(upd_taken_o), 32'(m_utk));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ghr"}, 32'(ghr_o), 32'h0);
    chk({tag, "_occ"}, 32'(occupancy_o), 32'h0);
    chk({tag, "_prdy"}, 32'(pred_ready_o), 32'h1);
    chk({tag, "_rrdy"}, 32'(res_ready_o), 32'h0);
    chk({tag, "_uv"}, 32'(upd_valid_o), 32'h0);
    chk({tag, "_upc"}, upd_pc_o, 32'h0);
    chk({tag, "_ughr"}, 32'(upd_ghr_o), 32'h0);
    chk({tag, "_utk"}, 32'(upd_taken_o), 32'h0);
    chk({tag, "_misp"}, 32'(mispredict_o), 32'h0);
  endtask

  // One clock: apply inputs, advance the model by the rules, compare.
  task automatic step(input string tag, input logic pv, input logic [31:0] pc,
                      input logic pt, input logic rv, input logic rt,
                      input logic fl);
    bit   pa, ra, mp;
    ent_t h;
    pred_valid_i = pv;
    pred_pc_i    = pc;
    pred_taken_i = pt;
    res_valid_i  = rv;
    res_taken_i  = rt;
    flush_i      = fl;
    pa = pv && !m_rec && mq.size() < 4;
    ra = rv && mq.size() > 0;
    mp = 1'b0;
    @(posedge clk);
    #1;
    m_uv = ra;
    if (ra) begin
      h      = mq.pop_front();
      m_upc  = h.pc;
      m_ughr = h.g;
      m_utk  = rt;
      m_arch = {m_arch[6:0], rt};
      mp     = (rt != h.t);
    end
    m_misp = mp;
    if (fl) begin
      mq.delete();
      m_spec = m_arch;
      m_rec  = 1'b1;
    end else if (mp) begin
      mq.delete();
      m_spec = {h.g[6:0], rt};
      m_rec  = 1'b1;
    end else begin
      m_rec = 1'b0;
      if (pa) begin
        mq.push_back('{pc: pc, g: m_spec, t: pt});
        m_spec = {m_spec[6:0], pt};
      end
    end
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    pred_valid_i = 1'b0;
    res_valid_i  = 1'b0;
    flush_i      = 1'b0;
    #2;
    model_reset();
    check_reset_outputs(tag);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    pred_valid_i = 1'b0;
    pred_pc_i    = 32'h0;
    pred_taken_i = 1'b0;
    res_valid_i  = 1'b0;
    res_taken_i  = 1'b0;
    flush_i      = 1'b0;
    model_reset();
    #7;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b1;

    step("tp1a", 1, 32'h1c000000, 1, 0, 0, 0);
    step("tp1b", 1, 32'h1c000004, 0, 0, 0, 0);
    step("tp1c", 1, 32'h1c000008, 1, 0, 0, 0);
    chk("tp1_ghr05", 32'(ghr_o), 32'h05);
    chk("tp1_occ3", 32'(occupancy_o), 32'h3);

    step("tp2a", 0, 32'h0, 0, 1, 1, 0);
    chk("tp2a_ughr", 32'(upd_ghr_o), 32'h00);
    chk("tp2a_upc", upd_pc_o, 32'h1c000000);
    step("tp2b", 0, 32'h0, 0, 1, 0, 0);
    chk("tp2b_ughr", 32'(upd_ghr_o), 32'h01);
    step("tp2c", 0, 32'h0, 0, 1, 1, 0);
    chk("tp2c_ughr", 32'(upd_ghr_o), 32'h02);
    chk("tp2c_misp", 32'(mispredict_o), 32'h0);
    step("tp2f", 0, 32'h0, 0, 0, 0, 1);
    chk("tp2_arch05", 32'(ghr_o), 32'h05);
    idle("tp2i");

    for (int i = 0; i < 4; i++)
      step("tp3p", 1, 32'h1c000100 + 32'(4 * i), 1, 0, 0, 0);
    chk("tp3_full_prdy", 32'(pred_ready_o), 32'h0);
    step("tp3s", 1, 32'h1c000200, 0, 1, 1, 0);
    chk("tp3_occ3", 32'(occupancy_o), 32'h3);
    chk("tp3_prdy1", 32'(pred_ready_o), 32'h1);
    for (int i = 0; i < 3; i++)
      step("tp3r", 0, 32'h0, 0, 1, 1, 0);

    do_reset("tp4rst");
    for (int i = 0; i < 3; i++)
      step("tp4p", 1, 32'h1c000300 + 32'(4 * i), 1, 0, 0, 0);
    step("tp4r1", 0, 32'h0, 0, 1, 1, 0);
    step("tp4r2", 0, 32'h0, 0, 1, 0, 0);
    chk("tp4_misp", 32'(mispredict_o), 32'h1);
    chk("tp4_ughr", 32'(upd_ghr_o), 32'h01);
    chk("tp4_utk", 32'(upd_taken_o), 32'h0);
    chk("tp4_ghr02", 32'(ghr_o), 32'h02);
    chk("tp4_prdy0", 32'(pred_ready_o), 32'h0);
    step("tp4drop", 1, 32'h1c000400, 1, 0, 0, 0);
    chk("tp4_occ0", 32'(occupancy_o), 32'h0);
    chk("tp4_ghr_kept", 32'(ghr_o), 32'h02);

    do_reset("tp5rst");
    step("tp5a", 1, 32'h1c000500, 1, 0, 0, 0);
    step("tp5b", 0, 32'h0, 0, 1, 1, 0);
    step("tp5c", 1, 32'h1c000504, 1, 0, 0, 0);
    step("tp5d", 1, 32'h1c000508, 1, 0, 0, 0);
    chk("tp5_ghr07", 32'(ghr_o), 32'h07);
    step("tp5f", 1, 32'h1c00050c, 1, 0, 0, 1);
    chk("tp5_ghr01", 32'(ghr_o), 32'h01);
    chk("tp5_occ0", 32'(occupancy_o), 32'h0);
    chk("tp5_prdy0", 32'(pred_ready_o), 32'h0);
    idle("tp5i");
    step("tp5g", 1, 32'h1c000510, 1, 0, 0, 0);
    step("tp5h", 1, 32'h1c000514, 1, 0, 0, 0);
    step("tp5fr", 0, 32'h0, 0, 1, 1, 1);
    chk("tp5_uv", 32'(upd_valid_o), 32'h1);
    chk("tp5_ghr03", 32'(ghr_o), 32'h03);
    idle("tp5j");

    for (int i = 0; i < 3; i++)
      step("tp6p", 1, 32'h1c000600 + 32'(4 * i), i[0], 0, 0, 0);
    step("tp6r", 0, 32'h0, 0, 1, 1, 0);
    do_reset("tp6rst");
    step("tp6a", 1, 32'h1c000700, 1, 0, 0, 0);
    step("tp6b", 0, 32'h0, 0, 1, 1, 0);
    chk("tp6_ughr00", 32'(upd_ghr_o), 32'h00);

    for (int i = 0; i < 600; i++) begin
      logic pv, pt, rv, rt, fl;
      pv = ($urandom_range(0, 99) < 60);
      pt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 99) < 50);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8)
        rt = mq[0].t;
      else
        rt = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 99) < 3);
      step("rnd", pv, {$urandom_range(0, 32'h3fffffff), 2'b00}, pt, rv, rt,
           fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
